// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Sequential PC generator with a single-outstanding instruction-memory
//   request port and a DEPTH-entry {inst, pc} FIFO toward decode.
//   Jump/branch redirects flush the FIFO and discard any in-flight response.
//
// Ports
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   imem_req_*          request handshake (valid/ready) and word address
//   imem_resp_*         response valid and instruction data
//   out_valid/ready     FIFO head handshake toward decode
//   out_inst, out_pc    FIFO head contents (undefined when out_valid=0)
//   stall               blocks new request issue only
//   jmp, jmp_addr       J-type redirect and its 26-bit target field
//   branch, offset      taken-branch redirect and its 16-bit word offset
//   redir_pc            PC of the redirecting instruction
//
// Optional feature macro: FETCH_PERF_EN
//   Adds perf_redirects[31:0] (redirect cycles) and perf_dropped[31:0]
//   (discarded responses); both cleared by reset and wrap at 2^32.
module fetch_queue_unit #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h8002_0000,
  parameter int          DEPTH    = 4,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              stall,
  input  logic              jmp,
  input  logic [25:0]       jmp_addr,
  input  logic              branch,
  input  logic [15:0]       offset,
  input  logic [ADDR_W-1:0] redir_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // free to issue a request
    S_WAIT = 2'd1,  // request accepted, response will be kept
    S_DROP = 2'd2   // request accepted, response will be discarded
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] next_pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;   // PC of the outstanding request
  logic [ADDR_W-1:0] jmp_target, br_target, redir_target, off_ext;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;

  logic redirect, accept, push, pop;

  assign redirect = jmp | branch;
  assign accept   = imem_req_valid & imem_req_ready;
  // A response arriving together with a redirect is discarded like a flushed entry.
  assign push     = (state_reg == S_WAIT) & imem_resp_valid & ~redirect;
  assign pop      = out_valid & out_ready;

  // Redirect targets. Jump keeps every PC bit above the 28-bit jump field.
  generate
    if (ADDR_W > 28) begin : g_jmp_hi
      assign jmp_target = {redir_pc[ADDR_W-1:28], jmp_addr, 2'b00};
    end else begin : g_jmp_lo
      assign jmp_target = {jmp_addr, 2'b00};
    end
  endgenerate

  assign off_ext      = {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
  assign br_target    = redir_pc + ADDR_W'(4) + off_ext;
  assign redir_target = jmp ? jmp_target : br_target;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = redirect ? S_DROP : S_WAIT;
      // A response in the redirect cycle itself is dropped here, so no DROP wait.
      S_WAIT: if (imem_resp_valid) state_next = S_IDLE;
              else if (redirect)   state_next = S_DROP;
      S_DROP: if (imem_resp_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Free-slot test uses the registered count only, so a same-cycle pop frees
  // its slot for issue one cycle later; IDLE implies nothing outstanding.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst_n && (state_reg == S_IDLE) && !stall && !redirect && (count_reg < DEPTH_C))
      imem_req_valid = 1'b1;
  end

  assign imem_req_addr = next_pc_reg;

  // ---------------- PC tracking ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_pc_reg <= RESET_PC_A;
      req_pc_reg  <= RESET_PC_A;
    end else begin
      if (accept) req_pc_reg <= next_pc_reg;
      if (redirect)    next_pc_reg <= redir_target;
      else if (accept) next_pc_reg <= next_pc_reg + ADDR_W'(4);
    end
  end

  // ---------------- FIFO control ----------------
  always_ff @(posedge clk) begin
    if (!rst_n || redirect) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage (no reset needed; validity tracked by count_reg).
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= imem_resp_data;
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_inst  = inst_mem[rd_ptr_reg];
  assign out_pc    = pc_mem[rd_ptr_reg];

`ifdef FETCH_PERF_EN
  logic drop_resp;
  assign drop_resp = imem_resp_valid &
                     ((state_reg == S_DROP) | ((state_reg == S_WAIT) & redirect));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_redirects <= '0;
      perf_dropped   <= '0;
    end else begin
      if (redirect)  perf_redirects <= perf_redirects + 32'd1;
      if (drop_resp) perf_dropped   <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-register PC fetch unit.
- Generates sequential PCs and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO toward decode.
- Jump/branch redirects flush the FIFO and discard any in-flight response; sits between the instruction memory port and the decode stage.

Parameters:
- ADDR_W, 32, PC and memory address width (≥ 28).
- RESET_PC, 32'h8002_0000, first PC fetched after reset (truncated to ADDR_W).
- DEPTH, 4, FIFO entries (power of two, ≥ 2).
- INST_W, 32, instruction word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  request address (word aligned).
- imem_resp_valid  in  1  response data valid (≥1 cycle after acceptance).
- imem_resp_data  in  INST_W  fetched instruction.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode consumes head.
- out_inst  out  INST_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- stall  in  1  blocks new request issue only; FIFO and responses unaffected.
- jmp  in  1  J-type redirect.
- jmp_addr  in  26  J-type target field.
- branch  in  1  taken-branch redirect.
- offset  in  16  branch word offset.
- redir_pc  in  ADDR_W  PC of the redirecting instruction.

Behaviour:
- Reset (rst_n=0 at posedge):
  - next_pc=RESET_PC; FIFO empty.
  - out_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC.
  - FSM=IDLE; drop flag cleared.
  - Reset mid-transaction abandons the outstanding response; the memory side must not return it after reset.
- Redirect targets (all arithmetic mod 2^ADDR_W):
  - jump: {redir_pc[ADDR_W-1:ADDR_W-4], …, jmp_addr, 2'b00}, with upper bits taken from redir_pc and width-adjusted to ADDR_W.
  - branch: redir_pc + 4 + (sign_extend(offset) << 2).
  - jmp has priority when jmp and branch are asserted together.
- Redirect (jmp|branch) in cycle N, applied at the posedge ending N, overriding all other updates:
  - FIFO flushed; out_valid=0 in N+1; next_pc=target.
  - If FSM=WAIT, FSM→DROP; if FSM=IDLE and a request is being accepted in N, FSM→DROP.
  - Redirect ignores stall.
- FSM:
  - IDLE: imem_req_valid=1 iff !stall and FIFO free slots ≥1 and no redirect this cycle. On valid&&ready: FSM→WAIT, next_pc+=4.
  - WAIT: imem_req_valid=0. On resp_valid: write {inst, pc} to FIFO, FSM→IDLE.
  - DROP: imem_req_valid=0. On resp_valid: discard the response, FSM→IDLE.
  - The response cycle may be the same cycle as the next request is issued: combinational IDLE decode is not required, so back-to-back throughput is 1 instruction per 2 cycles minimum.
- Space reservation: a request is issued only if a slot is free counting the outstanding one, so the FIFO never overflows.
- FIFO:
  - Push and pop in the same cycle allowed, including when full, since free-slot accounting excludes the popped entry only on the next cycle.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
  - out_inst/out_pc are registered from FIFO storage; undefined when out_valid=0.
- imem_req_addr holds next_pc and is stable while imem_req_valid=1 && !imem_req_ready.

Optional Feature:
- FETCH_PERF_EN defined: adds output ports perf_redirects[31:0] and perf_dropped[31:0].
  - Counters are cleared by reset, increment once per redirect cycle and once per discarded response, and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then out_ready=1, memory 1-cycle latency returning addr as data → requests at 8002_0000, 8002_0004, 8002_0008; out_pc/out_inst match in order, no gaps beyond 1 idle cycle per fetch.
- out_ready=0 with DEPTH=4 → exactly 4 entries accepted, imem_req_valid stays 0, and no overflow. Then one pop → exactly one new request issues.
- Branch redir_pc=8002_0010, offset=16'hFFFE while a request is in WAIT → response dropped, FIFO empty next cycle, next request addr 8002_000C.
- jmp=1 and branch=1 same cycle, redir_pc=8002_0000, jmp_addr=26'h000_0040 → next request addr 8000_0100.
- stall=1 for 5 cycles with FIFO draining → no new request issues during stall, and a redirect during stall still updates the next request addr. rst_n=0 while in WAIT → next_pc=8002_0000, FIFO empty.
- With FETCH_PERF_EN, the prior redirect test → perf_redirects=1, perf_dropped=1.
